// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART types and helpers shared by the transmit and receive paths
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Whole system clocks per serial bit; the fraction is dropped.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous FIFO with wrap-bit pointers and occupancy count
module byte_fifo
#(
  parameter int DEPTH  = 16,
  parameter int D_BITS = 8
)
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [D_BITS-1:0]        data_i,
  input  logic                     pop_i,
  output logic [D_BITS-1:0]        data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [D_BITS-1:0]  mem_q [DEPTH];
  logic               do_push;
  logic               do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Next pointer values: advance only on an accepted push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
  end

  // Pointer registers; clearing them flushes the contents.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; no reset needed since the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int clk_speed = 100_000000,
  parameter int baudrate  = 921600,
  parameter int D_BITS    = 8,
  parameter int SP_BITS   = 1,
  parameter int DEPTH     = 16
)
(
  input  logic                    i_clk,
  input  logic                    reset,
  input  logic [D_BITS-1:0]       i_data,
  input  logic                    i_valid,
  output logic                    o_rdy,
  output logic                    o_tx,
  output logic                    o_busy,
  output logic                    o_tx_done,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int CPB   = clks_per_bit(clk_speed, baudrate);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(D_BITS) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(D_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(SP_BITS - 1);

  tx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [D_BITS-1:0]  shift_q, shift_d;
  logic               tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [D_BITS-1:0]  fifo_dout;
  logic               done;

  assign o_rdy     = !fifo_full && !reset;
  assign fifo_push = i_valid && o_rdy;
  assign o_tx      = tx_q;
  assign o_busy    = (state_q != IDLE) || (o_count != '0);
  assign o_tx_done = done && !reset;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .D_BITS (D_BITS)
  ) u_fifo (
    .clk_i   (i_clk),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (i_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (o_count)
  );

  // Frame sequencer: each bit lasts CPB clocks; the line value is registered in tx_q.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    done     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d    = par_q;
`endif
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
          par_d    = ^fifo_dout;
`endif
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = START;
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == STOP_LAST) begin
            // Last stop clock: report completion and chain straight into the next frame.
            done  = 1'b1;
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
              par_d    = ^fifo_dout;
`endif
              tx_d     = 1'b0;
              state_d  = START;
            end else begin
              tx_d    = 1'b1;
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; reset abandons any frame and idles the line high.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - self-checking bench for uart_tx_buf
module tb_uart_tx_buf;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = (1 + 8 + PAR + 1) * CPB;

  logic       i_clk = 1'b0;
  logic       reset;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_rdy;
  logic       o_tx;
  logic       o_busy;
  logic       o_tx_done;
  logic [4:0] o_count;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  uart_tx_buf #(
    .clk_speed (1_000_000),
    .baudrate  (100_000),
    .D_BITS    (8),
    .SP_BITS   (1),
    .DEPTH     (DEPTH)
  ) dut (
    .i_clk     (i_clk),
    .reset     (reset),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .o_rdy     (o_rdy),
    .o_tx      (o_tx),
    .o_busy    (o_busy),
    .o_tx_done (o_tx_done),
    .o_count   (o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Line model: queue of accepted bytes plus the per-clock waveform of the frame on the wire.
  logic [7:0] mq[$];
  logic       wave[$];
  logic [7:0] sent_q[$];
  logic [7:0] rx_log[$];
  logic [7:0] exp_q[$];

  task automatic add_frame(input logic [7:0] b);
    for (int i = 0; i < CPB; i++) wave.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < CPB; i++) wave.push_back(b[k]);
    if (PAR == 1)
      for (int i = 0; i < CPB; i++) wave.push_back(^b);
    for (int i = 0; i < CPB; i++) wave.push_back(1'b1);
  endtask

  always @(posedge i_clk) begin
    logic       m_acc;
    logic [7:0] m_b;
    if (reset) begin
      mq.delete();
      wave.delete();
      sent_q.delete();
    end else begin
      m_acc = i_valid && (mq.size() < DEPTH);
      if (wave.size() > 0) void'(wave.pop_front());
      if (wave.size() == 0 && mq.size() > 0) begin
        m_b = mq.pop_front();
        sent_q.push_back(m_b);
        add_frame(m_b);
      end
      if (m_acc) mq.push_back(i_data);
    end
  end

  // Per-cycle compare against the model, plus a receiver decoding the DUT line.
  bit         rx_act = 0;
  int         rx_t;
  logic [7:0] rx_b;

  always @(negedge i_clk) begin
    int         j;
    logic [7:0] s;
    if (reset) begin
      rx_act = 0;
      if (started) chk("rdy_in_reset", o_rdy, 1'b0);
    end else if (started) begin
      chk("model_tx", o_tx, (wave.size() > 0) ? wave[0] : 1'b1);
      chk("model_done", o_tx_done, wave.size() == 1);
      chk("model_busy", o_busy, (wave.size() > 0) || (mq.size() > 0));
      chk("model_count", o_count, mq.size());
      chk("model_rdy", o_rdy, mq.size() < DEPTH);
      if (!rx_act && o_tx == 1'b0) begin
        rx_act = 1;
        rx_t   = 0;
      end
      if (rx_act) begin
        if (rx_t % CPB == CPB / 2) begin
          j = rx_t / CPB;
          if (j == 0) chk("rx_start_bit", o_tx, 1'b0);
          else if (j <= 8) rx_b[j-1] = o_tx;
          else if (PAR == 1 && j == 9) chk("rx_parity_bit", o_tx, ^rx_b);
          else begin
            chk("rx_stop_bit", o_tx, 1'b1);
            rx_log.push_back(rx_b);
            chk("rx_model_nonempty", sent_q.size() > 0, 1'b1);
            if (sent_q.size() > 0) begin
              s = sent_q.pop_front();
              chk("rx_vs_model", rx_b, s);
            end
            rx_act = 0;
          end
        end
        rx_t++;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (o_busy && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_idle_timeout"}, n >= budget, 1'b0);
    repeat (3) tick();
  endtask

  task automatic check_rx(input string tag);
    chk({tag, "_rx_count"}, rx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_log.size(); i++)
      chk($sformatf("%s_rx_byte%0d", tag, i), rx_log[i], exp_q[i]);
    rx_log.delete();
    exp_q.delete();
  endtask

  logic rec_tx[FRAME+20];
  logic rec_done[FRAME+20];

  // Push one byte into an idle transmitter and record the following clocks of the line.
  task automatic record_frame(input string tag, input logic [7:0] b);
    int d = 0;
    int di = -1;
    i_data  = b;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    chk({tag, "_tx_high_at_accept"}, o_tx, 1'b1);
    chk({tag, "_count_after_accept"}, o_count, 1);
    tick();
    for (int c = 0; c < FRAME + 20; c++) begin
      rec_tx[c]   = o_tx;
      rec_done[c] = o_tx_done;
      if (o_tx_done) begin
        d++;
        di = c;
      end
      tick();
    end
    chk({tag, "_start_first"}, rec_tx[0], 1'b0);
    chk({tag, "_start_mid"}, rec_tx[CPB/2], 1'b0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("%s_data%0d", tag, k), rec_tx[CPB + CPB/2 + k*CPB], b[k]);
    chk({tag, "_stop"}, rec_tx[FRAME - CPB/2], 1'b1);
    chk({tag, "_idle_after"}, rec_tx[FRAME], 1'b1);
    chk({tag, "_done_pulses"}, d, 1);
    chk({tag, "_done_cycle"}, di, FRAME - 1);
    chk({tag, "_busy_dropped"}, o_busy, 1'b0);
    exp_q.push_back(b);
    check_rx(tag);
  endtask

  initial begin
    int   n;
    int   d;
    int   acc;
    int   lows;
    bit   will;
    bit   seen_full;
    logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    reset   = 1'b1;
    i_valid = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge i_clk);
    #1;
    chk("reset_rdy_low", o_rdy, 1'b0);
    chk("reset_tx", o_tx, 1'b1);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_tx_done, 1'b0);
    chk("reset_count", o_count, 0);
    reset = 1'b0;
    #1;
    chk("rdy_after_reset", o_rdy, 1'b1);
    started = 1;

    // 1: single 0xA5 frame
    record_frame("t1", 8'hA5);
    for (int k = 0; k < 8; k++)
      chk($sformatf("t1_a5_literal%0d", k), rec_tx[CPB + CPB/2 + k*CPB], a5_bits[k]);
    chk("t1_frame_len", FRAME, 100 + 10 * PAR);

    // 2: three back-to-back frames
    i_valid = 1'b1;
    i_data  = 8'h00;
    tick();
    i_data = 8'hFF;
    tick();
    i_data = 8'h3C;
    tick();
    i_valid = 1'b0;
    n = 1;
    d = 0;
    while (n < 4 * FRAME) begin
      if (o_tx_done) d++;
      if (d == 3) break;
      tick();
      n++;
    end
    chk("t2_third_done_cycle", n, 3 * FRAME - 1);
    wait_idle("t2", 4 * FRAME);
    exp_q = '{8'h00, 8'hFF, 8'h3C};
    check_rx("t2");

    // 3: hold i_valid for DEPTH+2 cycles while a frame is on the line
    i_valid = 1'b1;
    i_data  = 8'h11;
    tick();
    i_valid = 1'b0;
    tick();
    i_data    = 8'h20;
    i_valid   = 1'b1;
    acc       = 0;
    seen_full = 0;
    for (int c = 0; c < DEPTH + 2; c++) begin
      will = o_rdy;
      tick();
      if (will) begin
        acc++;
        i_data = 8'(8'h20 + acc);
      end
      if (o_count == DEPTH && !seen_full) begin
        seen_full = 1;
        chk("t3_rdy_low_at_full", o_rdy, 1'b0);
      end
    end
    i_valid = 1'b0;
    chk("t3_accepted", acc, DEPTH);
    chk("t3_seen_full", seen_full, 1'b1);
    wait_idle("t3", (DEPTH + 3) * FRAME);
    exp_q.push_back(8'h11);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h20 + i));
    check_rx("t3");

    // 4: reset 35 clocks into a frame with another byte queued
    i_valid = 1'b1;
    i_data  = 8'h5A;
    tick();
    i_data = 8'h66;
    tick();
    i_valid = 1'b0;
    repeat (35) tick();
    reset = 1'b1;
    tick();
    chk("t4_tx_high", o_tx, 1'b1);
    chk("t4_count_zero", o_count, 0);
    chk("t4_busy_zero", o_busy, 1'b0);
    reset = 1'b0;
    d    = 0;
    lows = 0;
    for (int c = 0; c < FRAME + 20; c++) begin
      if (o_tx_done) d++;
      if (!o_tx) lows++;
      tick();
    end
    chk("t4_no_done", d, 0);
    chk("t4_line_idle", lows, 0);
    check_rx("t4_abandoned");
    record_frame("t4_after", 8'h81);

    // 5: full FIFO, push offered on the pop edge
    i_valid = 1'b1;
    i_data  = 8'h01;
    tick();
    i_valid = 1'b0;
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      i_data  = 8'(8'h40 + i);
      i_valid = 1'b1;
      tick();
    end
    i_data = 8'hEE;
    chk("t5_full_count", o_count, DEPTH);
    n = 0;
    while (!o_tx_done && n < 2 * FRAME) begin
      tick();
      n++;
    end
    chk("t5_done_seen", o_tx_done, 1'b1);
    chk("t5_rdy_low_on_pop_edge", o_rdy, 1'b0);
    chk("t5_count_before_pop", o_count, DEPTH);
    tick();
    chk("t5_count_after_pop", o_count, DEPTH - 1);
    chk("t5_rdy_after_pop", o_rdy, 1'b1);
    tick();
    i_valid = 1'b0;
    chk("t5_count_refill", o_count, DEPTH);
    wait_idle("t5", (DEPTH + 3) * FRAME);
    exp_q.push_back(8'h01);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'hEE);
    check_rx("t5");

`ifdef UART_TX_PARITY_EN
    // 6: parity bit values
    record_frame("t6a", 8'h07);
    chk("t6a_parity_one", rec_tx[9*CPB + CPB/2], 1'b1);
    chk("t6a_frame_110", FRAME, 110);
    record_frame("t6b", 8'h03);
    chk("t6b_parity_zero", rec_tx[9*CPB + CPB/2], 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
